// File: rtl/i2c_byte_engine.sv
// Byte-level I2C master: executes one start/read/write/stop command at a time
// and drives open-drain SCL/SDA pads, honouring slave clock stretching.
module i2c_byte_engine #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       start,
   input  logic       stop,
   input  logic       read,
   input  logic       write,
   input  logic       ack_in,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       cmd_ack,
   output logic       ack_out,
   output logic       busy,
   input  logic       scl_pad_i,
   output logic       scl_pad_o,
   output logic       scl_padoen_o,
   input  logic       sda_pad_i,
   output logic       sda_pad_o,
   output logic       sda_padoen_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE
   } state_t;

   localparam logic [15:0] QTR_LAST = 16'(CLK_DIV - 1);

   state_t      state, state_nxt;
   logic [15:0] qcnt;
   logic [1:0]  qtr;
   logic [2:0]  bit_cnt;
   logic        do_start, do_stop, do_xfer, do_write, ack_bit;
   logic [7:0]  tx_byte, rx_byte;
   logic        ack_smp, owned;
   logic        cmd_req, in_phase, stretch, qtr_end, phase_end, smp_edge;

   assign cmd_req   = start | stop | read | write;
   assign in_phase  = (state == S_START) || (state == S_DATA) ||
                      (state == S_ACK)   || (state == S_STOP);
   // A slave holding SCL low after release in q1 freezes the quarter counter.
   assign stretch   = in_phase && (qtr == 2'd1) && !scl_pad_i;
   assign qtr_end   = (qcnt == QTR_LAST) && !stretch;
   assign phase_end = qtr_end && (qtr == 2'd3);
   assign smp_edge  = qtr_end && (qtr == 2'd1);

   assign cmd_ack   = (state == S_DONE);
   assign busy      = in_phase;
   assign scl_pad_o = 1'b0;
   assign sda_pad_o = 1'b0;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_req) begin
               if (start)              state_nxt = S_START;
               else if (read || write) state_nxt = S_DATA;
               else                    state_nxt = S_STOP;
            end
         end
         S_START: begin
            if (phase_end)
               state_nxt = do_xfer ? S_DATA : (do_stop ? S_STOP : S_DONE);
         end
         S_DATA:  if (phase_end && (bit_cnt == 3'd0)) state_nxt = S_ACK;
         S_ACK:   if (phase_end) state_nxt = do_stop ? S_STOP : S_DONE;
         S_STOP:  if (phase_end) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      scl_padoen_o = 1'b1;
      sda_padoen_o = 1'b1;
      case (state)
         S_IDLE, S_DONE: scl_padoen_o = !owned;
         S_START: begin
            scl_padoen_o = (qtr != 2'd3);
            sda_padoen_o = (qtr < 2'd2);
         end
         S_DATA: begin
            scl_padoen_o = (qtr == 2'd1) || (qtr == 2'd2);
            sda_padoen_o = do_write ? tx_byte[bit_cnt] : 1'b1;
         end
         S_ACK: begin
            scl_padoen_o = (qtr == 2'd1) || (qtr == 2'd2);
            sda_padoen_o = do_write ? 1'b1 : ack_bit;
         end
         S_STOP: begin
            scl_padoen_o = (qtr != 2'd0);
            sda_padoen_o = (qtr == 2'd3);
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state    <= S_IDLE;
         qcnt     <= '0;
         qtr      <= '0;
         bit_cnt  <= 3'd7;
         do_start <= 1'b0;
         do_stop  <= 1'b0;
         do_xfer  <= 1'b0;
         do_write <= 1'b0;
         ack_bit  <= 1'b0;
         tx_byte  <= '0;
         rx_byte  <= '0;
         ack_smp  <= 1'b0;
         owned    <= 1'b0;
         dout     <= '0;
         ack_out  <= 1'b0;
      end else begin
         state <= state_nxt;

         if (!in_phase) begin
            qcnt    <= '0;
            qtr     <= '0;
            bit_cnt <= 3'd7;
         end else if (qtr_end) begin
            qcnt <= '0;
            qtr  <= qtr + 2'd1;
         end else if (!stretch) begin
            qcnt <= qcnt + 16'd1;
         end

         if ((state == S_IDLE) && cmd_req) begin
            do_start <= start;
            do_stop  <= stop;
            do_xfer  <= read | write;
            do_write <= write;
            ack_bit  <= ack_in;
            tx_byte  <= din;
         end

         if ((state == S_DATA) && phase_end) bit_cnt <= bit_cnt - 3'd1;
         if ((state == S_DATA) && smp_edge && !do_write)
            rx_byte <= {rx_byte[6:0], sda_pad_i};
         if ((state == S_ACK) && smp_edge && do_write)
            ack_smp <= sda_pad_i;

         if ((state == S_START) && phase_end) owned <= 1'b1;
         if ((state == S_STOP) && phase_end)  owned <= 1'b0;

         // Results become visible together with cmd_ack.
         if ((state_nxt == S_DONE) && (state != S_DONE) && do_xfer) begin
            if (do_write) ack_out <= ack_smp;
            else          dout    <= rx_byte;
         end
      end
   end

endmodule
